uart_loopback_bist: RTL and testbench

Synthesisable built-in self-test engine that drives the uart_controller TX interface and checks its RX interface with uart_tx/uart_rx tied externally. It is the on-chip successor to the directed loopback bench. It sends pseudo-random frames, compares received data and flags, and optionally sweeps every baud-rate select and every frame configuration. It sits beside uart_controller in the FPGA top and reports pass/fail, error counts and the first failing setting.

---
 rtl/uart_loopback_bist_if.sv | 30 +++
 rtl/uart_loopback_bist.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_loopback_bist.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loopback_bist_if.sv
// Signals between the loopback BIST engine and the uart_controller it exercises.
// The master side is the BIST engine; the slave side is the controller.
interface uart_loopback_bist_if #(
  parameter int BAUD_RATE_SEL_W = 2,
  parameter int TOTAL_CONF_W    = 5,
  parameter int MAX_UART_DATA_W = 8
);
  logic [BAUD_RATE_SEL_W-1:0] baud_sel_o;
  logic                       tx_en_o;
  logic                       rx_en_o;
  logic                       tx_start_o;
  logic [TOTAL_CONF_W-1:0]    tx_conf_o;
  logic [TOTAL_CONF_W-1:0]    rx_conf_o;
  logic [MAX_UART_DATA_W-1:0] tx_data_o;
  logic                       tx_done_i;
  logic                       rx_done_i;
  logic [MAX_UART_DATA_W-1:0] rx_data_i;
  logic                       rx_parity_err_i;
  logic                       rx_stop_err_i;

  modport master (
    output baud_sel_o, tx_en_o, rx_en_o, tx_start_o, tx_conf_o, rx_conf_o, tx_data_o,
    input  tx_done_i, rx_done_i, rx_data_i, rx_parity_err_i, rx_stop_err_i
  );

  modport slave (
    input  baud_sel_o, tx_en_o, rx_en_o, tx_start_o, tx_conf_o, rx_conf_o, tx_data_o,
    output tx_done_i, rx_done_i, rx_data_i, rx_parity_err_i, rx_stop_err_i
  );
endinterface

// File: rtl/uart_loopback_bist.sv
// Loopback BIST engine: sends LFSR frames through uart_controller, checks what comes
// back, and optionally sweeps every baud select and frame configuration.
//
// state   | meaning
// IDLE    | waiting for start
// SETUP   | apply baud/conf, enables low for one cycle, settle
// SEND    | launch one frame
// WAIT_TX | wait for tx_done (an early rx_done is latched)
// WAIT_RX | wait for rx_done
// CHECK   | compare received frame, update counters
// NEXT    | choose next frame, next setting, or finish
// DONE    | results held until next start
module uart_loopback_bist #(
  parameter int BAUD_RATE_SEL_W  = 2,
  parameter int N_BAUD_RATE_VALS = 4,
  parameter int TOTAL_CONF_W     = 5,
  parameter int MAX_UART_DATA_W  = 8,
  parameter int FRAME_CNT_W      = 16,
  parameter int ERR_CNT_W        = 16,
  parameter int TIMEOUT_CYCLES   = 200000,
  parameter int SETTLE_CYCLES    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic                       sweep_en_i,
  input  logic [BAUD_RATE_SEL_W-1:0] baud_sel_i,
  input  logic [TOTAL_CONF_W-1:0]    conf_i,
  input  logic [FRAME_CNT_W-1:0]     n_frames_i,
  input  logic [7:0]                 seed_i,
  uart_loopback_bist_if.master       uart,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic                       aborted_o,
  output logic                       timeout_o,
  output logic [FRAME_CNT_W-1:0]     frame_count_o,
  output logic [ERR_CNT_W-1:0]       err_count_o,
  output logic [BAUD_RATE_SEL_W-1:0] fail_baud_o,
  output logic [TOTAL_CONF_W-1:0]    fail_conf_o
);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BAUD_RATE_SEL_W-1:0] LAST_BAUD = BAUD_RATE_SEL_W'(N_BAUD_RATE_VALS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SEND, S_WAIT_TX, S_WAIT_RX, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t                     state_q;
  logic [7:0]                 lfsr_q;
  logic [BAUD_RATE_SEL_W-1:0] baud_q;
  logic [TOTAL_CONF_W-1:0]    conf_q;
  logic                       sweep_q;
  logic [FRAME_CNT_W-1:0]     n_lim_q;
  logic [FRAME_CNT_W-1:0]     frames_set_q;
  logic [SETTLE_W-1:0]        settle_q;
  logic [TMO_W-1:0]           tmo_q;
  logic                       rx_seen_q;
  logic [MAX_UART_DATA_W-1:0] rx_data_q;
  logic                       rx_perr_q;
  logic                       rx_serr_q;
  logic                       en_q;
  logic                       tx_start_q;
  logic [MAX_UART_DATA_W-1:0] tx_data_q;

  logic [MAX_UART_DATA_W-1:0] all_ones;
  logic [MAX_UART_DATA_W-1:0] data_mask;
  logic [3:0]                 n_bits;
  logic [7:0]                 lfsr_nxt;
  logic                       frame_bad;
  logic [ERR_CNT_W-1:0]       err_inc;

  assign all_ones  = '1;
  assign n_bits    = 4'd5 + {2'b00, conf_q[2:1]};
  assign data_mask = ~(all_ones << n_bits);
  assign lfsr_nxt  = lfsr_q[0] ? ((lfsr_q >> 1) ^ 8'hB8) : (lfsr_q >> 1);
  assign frame_bad = ((rx_data_q & data_mask) != tx_data_q) || rx_perr_q || rx_serr_q;
  assign err_inc   = (err_count_o == '1) ? err_count_o : err_count_o + ERR_CNT_W'(1);

  assign uart.baud_sel_o = baud_q;
  assign uart.tx_conf_o  = conf_q;
  assign uart.rx_conf_o  = conf_q;
  assign uart.tx_en_o    = en_q;
  assign uart.rx_en_o    = en_q;
  assign uart.tx_start_o = tx_start_q;
  assign uart.tx_data_o  = tx_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      lfsr_q        <= 8'h01;
      baud_q        <= '0;
      conf_q        <= '0;
      sweep_q       <= 1'b0;
      n_lim_q       <= '0;
      frames_set_q  <= '0;
      settle_q      <= '0;
      tmo_q         <= '0;
      rx_seen_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_perr_q     <= 1'b0;
      rx_serr_q     <= 1'b0;
      en_q          <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      aborted_o     <= 1'b0;
      timeout_o     <= 1'b0;
      frame_count_o <= '0;
      err_count_o   <= '0;
      fail_baud_o   <= '0;
      fail_conf_o   <= '0;
    end else if (abort_i && busy_o) begin
      // abort beats any CHECK update in the same cycle
      state_q    <= S_DONE;
      busy_o     <= 1'b0;
      done_o     <= 1'b1;
      pass_o     <= 1'b0;
      aborted_o  <= 1'b1;
      en_q       <= 1'b0;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q       <= S_SETUP;
            lfsr_q        <= (seed_i == 8'h00) ? 8'h01 : seed_i;
            sweep_q       <= sweep_en_i;
            baud_q        <= sweep_en_i ? '0 : baud_sel_i;
            conf_q        <= sweep_en_i ? '0 : conf_i;
            n_lim_q       <= (n_frames_i == '0) ? FRAME_CNT_W'(1) : n_frames_i;
            frames_set_q  <= '0;
            settle_q      <= SETTLE_W'(SETTLE_CYCLES - 1);
            en_q          <= 1'b0;
            busy_o        <= 1'b1;
            done_o        <= 1'b0;
            pass_o        <= 1'b0;
            aborted_o     <= 1'b0;
            timeout_o     <= 1'b0;
            frame_count_o <= '0;
            err_count_o   <= '0;
            fail_baud_o   <= '0;
            fail_conf_o   <= '0;
          end
        end
        S_SETUP: begin
          en_q <= 1'b1;
          if (settle_q == '0) state_q <= S_SEND;
          else                settle_q <= settle_q - SETTLE_W'(1);
        end
        S_SEND: begin
          tx_data_q  <= MAX_UART_DATA_W'(lfsr_q) & data_mask;
          tx_start_q <= 1'b1;
          tmo_q      <= TMO_W'(TIMEOUT_CYCLES - 1);
          rx_seen_q  <= 1'b0;
          state_q    <= S_WAIT_TX;
        end
        S_WAIT_TX, S_WAIT_RX: begin
          if (tmo_q == '0) begin
            timeout_o   <= 1'b1;
            err_count_o <= err_inc;
            if (err_count_o == '0) begin
              fail_baud_o <= baud_q;
              fail_conf_o <= conf_q;
            end
            state_q <= S_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            pass_o  <= 1'b0;
            en_q    <= 1'b0;
          end else begin
            tmo_q <= tmo_q - TMO_W'(1);
            // received word and flags are captured with rx_done, whichever state it lands in
            if (uart.rx_done_i) begin
              rx_seen_q <= 1'b1;
              rx_data_q <= uart.rx_data_i;
              rx_perr_q <= uart.rx_parity_err_i;
              rx_serr_q <= uart.rx_stop_err_i;
            end
            if (state_q == S_WAIT_TX) begin
              if (uart.tx_done_i) state_q <= S_WAIT_RX;
            end else if (uart.rx_done_i || rx_seen_q) begin
              state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          frame_count_o <= frame_count_o + FRAME_CNT_W'(1);
          if (frame_bad) begin
            err_count_o <= err_inc;
            if (err_count_o == '0) begin
              fail_baud_o <= baud_q;
              fail_conf_o <= conf_q;
            end
          end
          lfsr_q       <= lfsr_nxt;
          frames_set_q <= frames_set_q + FRAME_CNT_W'(1);
          state_q      <= S_NEXT;
        end
        S_NEXT: begin
          if (frames_set_q < n_lim_q) begin
            state_q <= S_SEND;
          end else if (sweep_q && !(conf_q == '1 && baud_q == LAST_BAUD)) begin
            if (conf_q == '1) baud_q <= baud_q + BAUD_RATE_SEL_W'(1);
            conf_q       <= conf_q + TOTAL_CONF_W'(1);
            frames_set_q <= '0;
            settle_q     <= SETTLE_W'(SETTLE_CYCLES - 1);
            en_q         <= 1'b0;
            state_q      <= S_SETUP;
          end else begin
            state_q <= S_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            pass_o  <= (err_count_o == '0);
            en_q    <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_loopback_bist.sv
// Bench for uart_loopback_bist: a behavioural loopback controller answers each frame,
// expected frames and end-of-run results are queued up front and checked by monitors.
module tb_uart_loopback_bist;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, sweep_en;
  logic [1:0]  baud_sel;
  logic [4:0]  conf;
  logic [15:0] n_frames;
  logic [7:0]  seed;
  logic        busy, done, pass, aborted, timeout;
  logic [15:0] frame_count, err_count;
  logic [1:0]  fail_baud;
  logic [4:0]  fail_conf;

  uart_loopback_bist_if #(.BAUD_RATE_SEL_W(2), .TOTAL_CONF_W(5), .MAX_UART_DATA_W(8)) bus ();

  uart_loopback_bist #(.TIMEOUT_CYCLES(1000)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .sweep_en_i(sweep_en),
    .baud_sel_i(baud_sel), .conf_i(conf), .n_frames_i(n_frames), .seed_i(seed),
    .uart(bus),
    .busy_o(busy), .done_o(done), .pass_o(pass), .aborted_o(aborted), .timeout_o(timeout),
    .frame_count_o(frame_count), .err_count_o(err_count),
    .fail_baud_o(fail_baud), .fail_conf_o(fail_conf)
  );

  typedef struct { logic [7:0] data; logic [1:0] baud; logic [4:0] conf; } frm_t;
  typedef struct {
    logic [15:0] frames; logic [15:0] errs;
    logic pass; logic aborted; logic tmo;
    logic [1:0] fb; logic [4:0] fc;
  } res_t;

  frm_t exp_frm[$];
  res_t exp_res[$];
  int   checks = 0;
  int   failures = 0;

  // loopback model controls
  int   tx_dly = 3, rx_dly = 5;
  bit   link_up = 1'b1;
  int   frame_no = 0, corrupt_frame = 0, par_frame = 0, stop_frame = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  function automatic logic [7:0] mask_of(input logic [4:0] c);
    case (c[2:1])
      2'd0:    return 8'h1F;
      2'd1:    return 8'h3F;
      2'd2:    return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic push_frames(input logic [1:0] b, input logic [4:0] c, input int n,
                             input logic [7:0] s);
    logic [7:0] l;
    l = s;
    for (int i = 0; i < n; i++) begin
      exp_frm.push_back('{data: l & mask_of(c), baud: b, conf: c});
      l = lfsr_step(l);
    end
  endtask

  task automatic push_res(input int frames, input int errs, input logic p, input logic ab,
                          input logic tm, input logic [1:0] fb, input logic [4:0] fc);
    exp_res.push_back('{frames: 16'(frames), errs: 16'(errs), pass: p, aborted: ab, tmo: tm,
                        fb: fb, fc: fc});
  endtask

  task automatic run_start(input logic sw, input logic [1:0] b, input logic [4:0] c,
                           input logic [15:0] n, input logic [7:0] s);
    @(negedge clk);
    sweep_en = sw; baud_sel = b; conf = c; n_frames = n; seed = s;
    frame_no = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int i;
    i = 0;
    while (!done && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_done_seen"}, 32'(done), 1);
    @(negedge clk);
  endtask

  task automatic wait_tx_start(input string name);
    int i;
    i = 0;
    while (!bus.tx_start_o && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_tx_start_seen"}, 32'(bus.tx_start_o), 1);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_status"}, 32'({busy, done, pass, aborted, timeout}), 0);
    chk({name, "_counts"}, 32'({frame_count, err_count}), 0);
    chk({name, "_fail_setting"}, 32'({fail_baud, fail_conf}), 0);
    chk({name, "_ctrl_bus"}, 32'({bus.baud_sel_o, bus.tx_en_o, bus.rx_en_o, bus.tx_start_o,
                                  bus.tx_conf_o, bus.rx_conf_o, bus.tx_data_o}), 0);
  endtask

  // behavioural uart_controller with tx tied to rx
  initial begin
    int tx_cnt, rx_cnt, pend_idx;
    logic [7:0] pend;
    tx_cnt = 0; rx_cnt = 0; pend_idx = 0; pend = '0;
    bus.tx_done_i = 1'b0; bus.rx_done_i = 1'b0; bus.rx_data_i = '0;
    bus.rx_parity_err_i = 1'b0; bus.rx_stop_err_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done_i = 1'b0; bus.rx_done_i = 1'b0;
      bus.rx_parity_err_i = 1'b0; bus.rx_stop_err_i = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) bus.tx_done_i = 1'b1;
      end
      if (rx_cnt > 0) begin
        rx_cnt--;
        if (rx_cnt == 0 && link_up) begin
          bus.rx_done_i       = 1'b1;
          bus.rx_data_i       = pend;
          bus.rx_parity_err_i = (pend_idx == par_frame);
          bus.rx_stop_err_i   = (pend_idx == stop_frame);
        end
      end
      if (bus.tx_start_o) begin
        frame_no++;
        pend_idx = frame_no;
        tx_cnt = tx_dly; rx_cnt = rx_dly;
        pend = bus.tx_data_o;
        if (frame_no == corrupt_frame) pend[0] = ~pend[0];
      end
    end
  end

  // monitor: every tx_start and every rising done is checked against the queues
  logic prev_start = 1'b0, prev_done = 1'b0;
  initial begin
    frm_t f;
    res_t r;
    forever begin
      @(negedge clk);
      if (bus.tx_start_o) begin
        chk("tx_start_single_cycle", 32'(prev_start), 0);
        if (exp_frm.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_start_unexpected: got data 0x%0h, expected no frame", bus.tx_data_o);
        end else begin
          f = exp_frm.pop_front();
          chk("tx_data", 32'(bus.tx_data_o), 32'(f.data));
          chk("baud_sel", 32'(bus.baud_sel_o), 32'(f.baud));
          chk("tx_conf", 32'(bus.tx_conf_o), 32'(f.conf));
          chk("rx_conf", 32'(bus.rx_conf_o), 32'(f.conf));
          chk("enables_on_send", 32'({bus.tx_en_o, bus.rx_en_o}), 3);
        end
      end
      if (done && !prev_done) begin
        if (exp_res.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected: got done_o=1, expected no run end");
        end else begin
          r = exp_res.pop_front();
          chk("frame_count", 32'(frame_count), 32'(r.frames));
          chk("err_count", 32'(err_count), 32'(r.errs));
          chk("pass", 32'(pass), 32'(r.pass));
          chk("aborted", 32'(aborted), 32'(r.aborted));
          chk("timeout", 32'(timeout), 32'(r.tmo));
          chk("fail_setting", 32'({fail_baud, fail_conf}), 32'({r.fb, r.fc}));
          chk("idle_at_done", 32'({busy, bus.tx_en_o, bus.rx_en_o}), 0);
        end
      end
      prev_start = bus.tx_start_o;
      prev_done  = done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] l;
    logic [7:0] t1 [4];
    int lat, n_st, i;
    rst = 1'b1; start = 1'b0; abort = 1'b0; sweep_en = 1'b0;
    baud_sel = '0; conf = '0; n_frames = '0; seed = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // single setting, 8-bit data; LFSR sequence from A5 worked by hand
    t1 = '{8'hA5, 8'hEA, 8'h75, 8'h82};
    for (int k = 0; k < 4; k++) exp_frm.push_back('{data: t1[k], baud: 2'd0, conf: 5'b00110});
    push_res(4, 0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0);
    run_start(1'b0, 2'd0, 5'b00110, 16'd4, 8'hA5);
    wait_done("single", 500);

    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    chk("abort_ignored_in_done", 32'({done, pass, aborted}), 32'b110);

    // full sweep, one frame per setting; a mid-run start must be ignored
    l = 8'h5C;
    for (int b = 0; b < 4; b++)
      for (int c = 0; c < 32; c++) begin
        exp_frm.push_back('{data: l & mask_of(5'(c)), baud: 2'(b), conf: 5'(c)});
        l = lfsr_step(l);
      end
    push_res(128, 0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0);
    run_start(1'b1, 2'd2, 5'b10101, 16'd0, 8'h5C);
    repeat (300) @(negedge clk);
    sweep_en = 1'b0; n_frames = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("sweep", 8000);

    // corrupted bit0 on 3rd frame, rx_done arriving before tx_done
    tx_dly = 6; rx_dly = 3; corrupt_frame = 3;
    push_frames(2'd2, 5'b00011, 4, 8'h3C);
    push_res(4, 1, 1'b0, 1'b0, 1'b0, 2'd2, 5'b00011);
    run_start(1'b0, 2'd2, 5'b00011, 16'd4, 8'h3C);
    wait_done("corrupt", 500);
    tx_dly = 3; rx_dly = 5; corrupt_frame = 0;

    // parity error on frame 1, stop error on frame 2
    par_frame = 1; stop_frame = 2;
    push_frames(2'd1, 5'b10101, 2, 8'h81);
    push_res(2, 2, 1'b0, 1'b0, 1'b0, 2'd1, 5'b10101);
    run_start(1'b0, 2'd1, 5'b10101, 16'd2, 8'h81);
    wait_done("flags", 500);
    par_frame = 0; stop_frame = 0;

    // receiver disconnected: timeout about 1000 cycles after tx_start
    link_up = 1'b0;
    push_frames(2'd3, 5'd0, 1, 8'h10);
    push_res(0, 1, 1'b0, 1'b0, 1'b1, 2'd3, 5'd0);
    run_start(1'b0, 2'd3, 5'd0, 16'd2, 8'h10);
    wait_tx_start("timeout");
    lat = 0;
    while (!timeout && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    chk("timeout_latency_near_1000", 32'(lat >= 999 && lat <= 1001), 1);
    wait_done("timeout", 100);
    link_up = 1'b1;

    // abort during 2nd of 5 frames, then a clean rerun
    push_frames(2'd0, 5'b00110, 2, 8'h77);
    push_res(1, 0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0);
    run_start(1'b0, 2'd0, 5'b00110, 16'd5, 8'h77);
    n_st = 0; i = 0;
    while (n_st < 2 && i < 500) begin
      @(negedge clk);
      i++;
      if (bus.tx_start_o) n_st++;
    end
    chk("abort_second_frame_started", 32'(n_st), 2);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort", 50);
    push_frames(2'd0, 5'b00110, 2, 8'h77);
    push_res(2, 0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0);
    run_start(1'b0, 2'd0, 5'b00110, 16'd2, 8'h77);
    wait_done("rerun", 500);

    // reset while waiting for rx, then seed 0 falls back to 8'h01
    push_frames(2'd0, 5'd0, 1, 8'h33);
    run_start(1'b0, 2'd0, 5'd0, 16'd3, 8'h33);
    wait_tx_start("midrun");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrun_reset");
    rst = 1'b0;
    exp_frm.push_back('{data: 8'h01, baud: 2'd0, conf: 5'd0});
    push_res(1, 0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0);
    run_start(1'b0, 2'd0, 5'd0, 16'd1, 8'h00);
    wait_done("seed_zero", 500);

    chk("frames_all_seen", 32'(exp_frm.size()), 0);
    chk("results_all_seen", 32'(exp_res.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
